// File: rtl/text_term_ctrl.sv
// Character-stream terminal engine: decodes ASCII bytes into character RAM writes,
// tracks the cursor and a circular top-row offset for hardware scrolling.
`timescale 1ns/1ps
module text_term_ctrl #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic [3:0]  fg_color,
  input  logic [3:0]  bg_color,
  output logic        mem_we,
  output logic [12:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic [12:0] mem_raddr,
  output logic [23:0] ctrl_reg
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLRLINE, S_CLS} state_e;

  state_e     state_q, state_d;
  logic [7:0] cur_x_q, cur_x_d;
  logic [4:0] cur_y_q, cur_y_d;
  logic [4:0] top_q, top_d;
  logic [4:0] clr_row_q, clr_row_d;
  logic [7:0] clr_col_q, clr_col_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       bs_q, bs_d;
  logic       line_adv;
  logic       we_raw;
  logic [4:0] cur_phys;

  // Row addition modulo ROWS by compare-and-subtract; both operands are < ROWS.
  function automatic logic [4:0] row_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [4:0] row_inc(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
  endfunction

  assign cur_phys  = row_add(cur_y_q, top_q);
  assign mem_raddr = {row_add(rd_y, top_q), rd_x};
  assign ctrl_reg  = {fg_color, bg_color, 3'b000, cur_y_q, cur_x_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CLS;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      top_q     <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      wbyte_q   <= BLANK;
      bs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      top_q     <= top_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      wbyte_q   <= wbyte_d;
      bs_q      <= bs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    top_d     = top_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    wbyte_d   = wbyte_q;
    bs_d      = bs_q;
    line_adv  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ch_valid) begin
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            wbyte_d = ch_data;
            bs_d    = 1'b0;
            state_d = S_WRITE;
          end else begin
            case (ch_data)
              8'h0D: cur_x_d = '0;
              8'h0A: begin
                cur_x_d  = '0;
                line_adv = 1'b1;
              end
              8'h08: begin
                if (cur_x_q != '0) begin
                  cur_x_d = cur_x_q - 8'd1;
                  wbyte_d = BLANK;
                  bs_d    = 1'b1;
                  state_d = S_WRITE;
                end
              end
              8'h0C: begin
                cur_x_d   = '0;
                cur_y_d   = '0;
                top_d     = '0;
                clr_row_d = '0;
                clr_col_d = '0;
                state_d   = S_CLS;
              end
              default: ;
            endcase
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (!bs_q) begin
          if (cur_x_q < LAST_COL) begin
            cur_x_d = cur_x_q + 8'd1;
          end else begin
            cur_x_d  = '0;
            line_adv = 1'b1;
          end
        end
      end
      S_CLRLINE: begin
        if (clr_col_q == LAST_COL) state_d = S_IDLE;
        else                       clr_col_d = clr_col_q + 8'd1;
      end
      S_CLS: begin
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          if (clr_row_q == LAST_ROW) state_d = S_IDLE;
          else                       clr_row_d = clr_row_q + 5'd1;
        end else begin
          clr_col_d = clr_col_q + 8'd1;
        end
      end
      default: state_d = S_CLS;
    endcase

    // Scrolling: the old top physical row becomes the new bottom line and is blanked.
    if (line_adv) begin
      if (cur_y_q < LAST_ROW) begin
        cur_y_d = cur_y_q + 5'd1;
      end else begin
        clr_row_d = top_q;
        clr_col_d = '0;
        top_d     = row_inc(top_q);
        state_d   = S_CLRLINE;
      end
    end
  end

  always_comb begin
    ch_ready  = 1'b0;
    we_raw    = 1'b0;
    mem_waddr = {clr_row_q, clr_col_q};
    mem_wdata = BLANK;
    unique case (state_q)
      S_IDLE: ch_ready = 1'b1;
      S_WRITE: begin
        we_raw    = 1'b1;
        mem_waddr = {cur_phys, cur_x_q};
        mem_wdata = wbyte_q;
      end
      S_CLRLINE, S_CLS: we_raw = 1'b1;
      default: ;
    endcase
  end

  // The reset state is CLS, but no write may be issued while reset is held.
  assign mem_we = we_raw & reset_n;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Randomized bench for text_term_ctrl: a screen-level model predicts every RAM write,
// busy duration, cursor and read-address translation.
`timescale 1ns/1ps
module tb_text_term_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = '0;
  logic        ch_ready;
  logic [3:0]  fg_color = '0;
  logic [3:0]  bg_color = '0;
  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic [7:0]  rd_x = '0;
  logic [4:0]  rd_y = '0;
  logic [12:0] mem_raddr;
  logic [23:0] ctrl_reg;

  text_term_ctrl #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .fg_color(fg_color), .bg_color(bg_color),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .rd_x(rd_x), .rd_y(rd_y), .mem_raddr(mem_raddr), .ctrl_reg(ctrl_reg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] exp_w;
  int m_x = 0, m_y = 0, m_top = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] wr(input int row, input int col, input logic [7:0] d);
    return {5'(row), 8'(col), d};
  endfunction

  task automatic push_blank_row(input int row);
    for (int c = 0; c < 80; c++) exp_q.push_back(wr(row, c, 8'h20));
  endtask

  task automatic model_line_adv(inout int busy);
    if (m_y < 29) m_y++;
    else begin
      push_blank_row(m_top);
      m_top = (m_top + 1) % 30;
      busy += 80;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output int busy);
    busy = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(wr((m_y + m_top) % 30, m_x, b));
      busy = 1;
      if (m_x < 79) m_x++;
      else begin
        m_x = 0;
        model_line_adv(busy);
      end
    end else if (b == 8'h0D) begin
      m_x = 0;
    end else if (b == 8'h0A) begin
      m_x = 0;
      model_line_adv(busy);
    end else if (b == 8'h08) begin
      if (m_x > 0) begin
        m_x--;
        exp_q.push_back(wr((m_y + m_top) % 30, m_x, 8'h20));
        busy = 1;
      end
    end else if (b == 8'h0C) begin
      m_x = 0; m_y = 0; m_top = 0;
      for (int r = 0; r < 30; r++) push_blank_row(r);
      busy = 2400;
    end
  endtask

  // Every observed write must be the next one the model predicted.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) exp_w = 21'h1FFFFF;
      else exp_w = exp_q.pop_front();
      chk("wr", {mem_waddr, mem_wdata}, exp_w);
    end
  end

  task automatic send(input logic [7:0] b, input bit wait_done);
    int n;
    int busy;
    int lo;
    n = 0;
    fg_color = 4'($urandom);
    bg_color = 4'($urandom);
    ch_valid = 1'b1;
    ch_data  = b;
    while (!ch_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ch_ready) begin
      chk("ready_timeout", 0, 1);
      ch_valid = 1'b0;
      return;
    end
    model_byte(b, busy);
    @(negedge clk);
    ch_valid = 1'b0;
    if (!wait_done) return;
    lo = 0;
    while (!ch_ready && lo < 3000) begin
      lo++;
      @(negedge clk);
    end
    chk("busy", lo, busy);
    chk("ctrl", ctrl_reg, {fg_color, bg_color, 3'b000, 5'(m_y), 8'(m_x)});
    chk("pend", exp_q.size(), 0);
    rd_x = 8'($urandom_range(0, 79));
    rd_y = 5'($urandom_range(0, 29));
    #1;
    chk("raddr", mem_raddr, {5'((int'(rd_y) + m_top) % 30), rd_x});
  endtask

  task automatic do_reset();
    int lo;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_ready", ch_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 8'h20);
    chk("rst_cursor", ctrl_reg[12:0], 0);
    exp_q.delete();
    m_x = 0; m_y = 0; m_top = 0;
    for (int r = 0; r < 30; r++) push_blank_row(r);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    lo = 0;
    @(negedge clk);
    while (!ch_ready && lo < 3000) begin
      lo++;
      @(negedge clk);
    end
    chk("cls_len", lo, 2400);
    chk("cls_pend", exp_q.size(), 0);
    chk("cls_cursor", ctrl_reg[12:0], 0);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    do_reset();

    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    send(8'h0D, 1'b1);
    send(8'h0A, 1'b1);
    for (int i = 0; i < 80; i++) send(8'h78, 1'b1);
    for (int i = 0; i < 40 && m_y < 29; i++) send(8'h0A, 1'b1);
    send(8'h0A, 1'b1);
    rd_x = 8'd3; rd_y = 5'd29; #1;
    chk("scroll_raddr_bottom", mem_raddr, {5'd0, 8'd3});
    rd_y = 5'd0; #1;
    chk("scroll_raddr_top", mem_raddr, {5'd1, 8'd3});
    for (int i = 0; i < 30; i++) send(8'h0A, 1'b1);

    send(8'h0D, 1'b1);
    send(8'h08, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h68, 1'b1);
    send(8'h08, 1'b1);
    send(8'h07, 1'b1);
    send(8'h0C, 1'b1);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 75) b = 8'h0A;
      else if (r < 82) b = 8'h0D;
      else if (r < 92) b = 8'h08;
      else if (r < 99) b = 8'($urandom_range(8'h7F, 8'hFF));
      else             b = 8'h0C;
      send(b, 1'b1);
    end

    for (int i = 0; i < 40 && m_y < 29; i++) send(8'h0A, 1'b1);
    send(8'h0A, 1'b0);
    repeat (10) @(negedge clk);
    do_reset();
    send(8'h5A, 1'b1);
    send(8'h0A, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
